// File: rtl/mini_src_control_unit.sv
// Hardwired step-counter sequencer for the single-bus Mini SRC datapath.
// Outputs are decoded from the registered step and the IR opcode.
module mini_src_control_unit #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        ConFF_Out,
  input  logic        Stop,
  output logic        Run,
  output logic        DP_Clear,
  output logic [4:0]  CONTROL,
  output logic        IncPC, Read, Write, Con_In,
  output logic        PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out,
  output logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In,
  output logic        InPort_In, OutPort_In,
  output logic        G_RA, G_RB, G_RC, R_In, R_Out, BA_Out
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_T9, S_STOP, S_HALT
  } state_t;

  state_t st, nxt, last;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge Clock or negedge Clear)
    if (!Clear) st <= S_RESET;
    else        st <= nxt;

  // final execute step per opcode class
  always_comb begin
    last = S_T4;
    case (op) inside
      5'd0:           last = S_T9;
      5'd1:           last = S_T6;
      5'd2:           last = S_T8;
      [5'd3:5'd14]:   last = S_T6;
      [5'd15:5'd16]:  last = S_T7;
      [5'd17:5'd18]:  last = S_T5;
      5'd19:          last = S_T7;
      5'd22:          last = S_T5;
      default:        last = S_T4;
    endcase
  end

  always_comb begin
    nxt = st;
    Run = 1'b0; DP_Clear = 1'b0; CONTROL = 5'd0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0; Con_In = 1'b0;
    PC_Out = 1'b0; MDR_Out = 1'b0; ZHI_Out = 1'b0; ZLO_Out = 1'b0;
    HI_Out = 1'b0; LO_Out = 1'b0; C_Out = 1'b0; InPort_Out = 1'b0;
    PC_In = 1'b0; MDR_In = 1'b0; MAR_In = 1'b0; IR_In = 1'b0; Y_In = 1'b0;
    ZHI_In = 1'b0; ZLO_In = 1'b0; HI_In = 1'b0; LO_In = 1'b0;
    InPort_In = 1'b0; OutPort_In = 1'b0;
    G_RA = 1'b0; G_RB = 1'b0; G_RC = 1'b0; R_In = 1'b0; R_Out = 1'b0; BA_Out = 1'b0;

    case (st)
      S_RESET: begin DP_Clear = 1'b1; nxt = S_T0; end
      S_STOP:  if (!Stop) nxt = S_T0;
      S_HALT:  nxt = S_HALT;
      // a pause taken at T0 must not bump PC, or resuming would skip an instruction
      S_T0: begin
        Run = 1'b1;
        if (Stop) nxt = S_STOP;
        else begin PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; nxt = S_T1; end
      end
      S_T1: begin Run = 1'b1; Read = 1'b1; nxt = S_T2; end
      S_T2: begin Run = 1'b1; Read = 1'b1; MDR_In = 1'b1; nxt = S_T3; end
      S_T3: begin Run = 1'b1; MDR_Out = 1'b1; IR_In = 1'b1; nxt = S_T4; end
      default: begin
        Run = 1'b1;
        nxt = (st == last) ? S_T0 : state_t'(st + 4'd1);
        if (op == 5'd27) nxt = S_HALT;
        case (op) inside
          [5'd0:5'd2]: case (st)
            S_T4: begin G_RB = 1'b1; BA_Out = 1'b1; Y_In = 1'b1; end
            S_T5: begin C_Out = 1'b1; CONTROL = ALU_ADD; ZLO_In = 1'b1; end
            S_T6: begin
              ZLO_Out = 1'b1;
              if (op == 5'd1) begin G_RA = 1'b1; R_In = 1'b1; end
              else            MAR_In = 1'b1;
            end
            S_T7: if (op == 5'd2) begin G_RA = 1'b1; R_Out = 1'b1; MDR_In = 1'b1; end
                  else            Read = 1'b1;
            S_T8: if (op == 5'd2) Write = 1'b1;
                  else begin Read = 1'b1; MDR_In = 1'b1; end
            S_T9: begin MDR_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
            default: ;
          endcase
          [5'd3:5'd14]: case (st)
            S_T4: begin G_RB = 1'b1; R_Out = 1'b1; Y_In = 1'b1; end
            S_T5: begin
              ZLO_In = 1'b1;
              case (op)
                5'd12:   begin C_Out = 1'b1; CONTROL = ALU_ADD; end
                5'd13:   begin C_Out = 1'b1; CONTROL = ALU_AND; end
                5'd14:   begin C_Out = 1'b1; CONTROL = ALU_OR;  end
                default: begin G_RC = 1'b1; R_Out = 1'b1; CONTROL = op; end
              endcase
            end
            S_T6: begin ZLO_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
            default: ;
          endcase
          [5'd15:5'd16]: case (st)
            S_T4: begin G_RA = 1'b1; R_Out = 1'b1; Y_In = 1'b1; end
            S_T5: begin G_RB = 1'b1; R_Out = 1'b1; CONTROL = op; ZHI_In = 1'b1; ZLO_In = 1'b1; end
            S_T6: begin ZLO_Out = 1'b1; LO_In = 1'b1; end
            S_T7: begin ZHI_Out = 1'b1; HI_In = 1'b1; end
            default: ;
          endcase
          [5'd17:5'd18]: case (st)
            S_T4: begin G_RB = 1'b1; R_Out = 1'b1; CONTROL = op; ZLO_In = 1'b1; end
            S_T5: begin ZLO_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
            default: ;
          endcase
          5'd19: case (st)
            S_T4: begin G_RA = 1'b1; R_Out = 1'b1; Con_In = 1'b1; end
            S_T5: begin PC_Out = 1'b1; Y_In = 1'b1; end
            S_T6: begin C_Out = 1'b1; CONTROL = ALU_ADD; ZLO_In = 1'b1; end
            S_T7: begin ZLO_Out = 1'b1; PC_In = ConFF_Out; end
            default: ;
          endcase
          5'd20: begin G_RA = 1'b1; R_Out = 1'b1; PC_In = 1'b1; end
          5'd22: if (st == S_T4) InPort_In = 1'b1;
                 else begin InPort_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
          5'd23: begin G_RA = 1'b1; R_Out = 1'b1; OutPort_In = 1'b1; end
          5'd24: begin HI_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
          5'd25: begin LO_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Scoreboard bench for mini_src_control_unit: each queued item carries the
// inputs for one cycle and the full expected strobe vector for that cycle.
module tb_mini_src_control_unit;

  logic        Clock = 1'b0, Clear, ConFF_Out, Stop;
  logic [31:0] IR;
  logic        Run, DP_Clear, IncPC, Read, Write, Con_In;
  logic        PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out;
  logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In, InPort_In, OutPort_In;
  logic        G_RA, G_RB, G_RC, R_In, R_Out, BA_Out;
  logic [4:0]  CONTROL;

  mini_src_control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .ConFF_Out(ConFF_Out), .Stop(Stop),
    .Run(Run), .DP_Clear(DP_Clear), .CONTROL(CONTROL),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Con_In(Con_In),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZHI_Out(ZHI_Out), .ZLO_Out(ZLO_Out),
    .HI_Out(HI_Out), .LO_Out(LO_Out), .C_Out(C_Out), .InPort_Out(InPort_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
    .ZHI_In(ZHI_In), .ZLO_In(ZLO_In), .HI_In(HI_In), .LO_In(LO_In),
    .InPort_In(InPort_In), .OutPort_In(OutPort_In),
    .G_RA(G_RA), .G_RB(G_RB), .G_RC(G_RC), .R_In(R_In), .R_Out(R_Out), .BA_Out(BA_Out)
  );

  always #5 Clock = ~Clock;

  localparam logic [35:0] RUN = 36'd1 << 0,  DPC = 36'd1 << 1,  INCPC = 36'd1 << 2,
    RD = 36'd1 << 3,  WR = 36'd1 << 4,  CONIN = 36'd1 << 5,  PCO = 36'd1 << 6,
    MDRO = 36'd1 << 7,  ZHIO = 36'd1 << 8,  ZLOO = 36'd1 << 9,  HIO = 36'd1 << 10,
    LOO = 36'd1 << 11, CO = 36'd1 << 12, INPO = 36'd1 << 13, PCI = 36'd1 << 14,
    MDRI = 36'd1 << 15, MARI = 36'd1 << 16, IRI = 36'd1 << 17, YI = 36'd1 << 18,
    ZHII = 36'd1 << 19, ZLOI = 36'd1 << 20, HII = 36'd1 << 21, LOI = 36'd1 << 22,
    INPI = 36'd1 << 23, OUTPI = 36'd1 << 24, GRA = 36'd1 << 25, GRB = 36'd1 << 26,
    GRC = 36'd1 << 27, RIN = 36'd1 << 28, ROUT = 36'd1 << 29, BAO = 36'd1 << 30;

  function automatic logic [35:0] ctl(input logic [4:0] c);
    return {c, 31'd0};
  endfunction

  logic [35:0] obs;
  assign obs = {CONTROL, BA_Out, R_Out, R_In, G_RC, G_RB, G_RA, OutPort_In, InPort_In,
                LO_In, HI_In, ZLO_In, ZHI_In, Y_In, IR_In, MAR_In, MDR_In, PC_In,
                InPort_Out, C_Out, LO_Out, HI_Out, ZLO_Out, ZHI_Out, MDR_Out, PC_Out,
                Con_In, Write, Read, IncPC, DP_Clear, Run};

  typedef struct {
    string       tag;
    logic [31:0] ir;
    logic        cf;
    logic        sp;
    logic [35:0] exp;
  } item_t;

  item_t q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] ir, input logic cf,
                      input logic sp, input logic [35:0] exp);
    item_t it;
    it.tag = tag; it.ir = ir; it.cf = cf; it.sp = sp; it.exp = exp;
    q.push_back(it);
  endtask

  task automatic fetch(input string tag, input logic [31:0] ir, input logic cf);
    push({tag, ".T0"}, ir, cf, 1'b0, RUN | PCO | MARI | INCPC);
    push({tag, ".T1"}, ir, cf, 1'b0, RUN | RD);
    push({tag, ".T2"}, ir, cf, 1'b0, RUN | RD | MDRI);
    push({tag, ".T3"}, ir, cf, 1'b0, RUN | MDRO | IRI);
  endtask

  task automatic drain();
    item_t it;
    while (q.size() != 0) begin
      it = q.pop_front();
      @(posedge Clock);
      #1 IR = it.ir; ConFF_Out = it.cf; Stop = it.sp;
      #1 chk(it.tag, obs, it.exp);
    end
  endtask

  localparam logic [31:0] I_ADD = 32'h18918000, I_LD = 32'h01000055, I_BR = 32'h98880005,
    I_ANDI = 32'h6911000F, I_ST = 32'h10800010, I_NEG = 32'h88900000, I_MFHI = 32'hC0800000,
    I_NOP = 32'hD0000000, I_MUL = 32'h79180000, I_HALT = 32'hD8000000;

  initial begin
    Clear = 1'b0; Stop = 1'b0; IR = '0; ConFF_Out = 1'b0;
    repeat (2) begin
      @(negedge Clock);
      chk("reset", obs, DPC);
    end
    Clear = 1'b1;

    fetch("add", I_ADD, 1'b0);
    push("add.T4", I_ADD, 1'b0, 1'b0, RUN | GRB | ROUT | YI);
    push("add.T5", I_ADD, 1'b0, 1'b0, RUN | GRC | ROUT | ZLOI | ctl(5'b00011));
    push("add.T6", I_ADD, 1'b0, 1'b0, RUN | ZLOO | GRA | RIN);

    fetch("ld", I_LD, 1'b0);
    push("ld.T4", I_LD, 1'b0, 1'b0, RUN | GRB | BAO | YI);
    push("ld.T5", I_LD, 1'b0, 1'b0, RUN | CO | ZLOI | ctl(5'b00011));
    push("ld.T6", I_LD, 1'b0, 1'b0, RUN | ZLOO | MARI);
    push("ld.T7", I_LD, 1'b0, 1'b0, RUN | RD);
    push("ld.T8", I_LD, 1'b0, 1'b0, RUN | RD | MDRI);
    push("ld.T9", I_LD, 1'b0, 1'b0, RUN | MDRO | GRA | RIN);

    for (int k = 0; k < 2; k++) begin
      logic cf;
      cf = (k == 1);
      fetch("br", I_BR, cf);
      push("br.T4", I_BR, cf, 1'b0, RUN | GRA | ROUT | CONIN);
      push("br.T5", I_BR, cf, 1'b0, RUN | PCO | YI);
      push("br.T6", I_BR, cf, 1'b0, RUN | CO | ZLOI | ctl(5'b00011));
      push("br.T7", I_BR, cf, 1'b0, RUN | ZLOO | (cf ? PCI : 36'd0));
    end

    fetch("andi", I_ANDI, 1'b0);
    push("andi.T4", I_ANDI, 1'b0, 1'b0, RUN | GRB | ROUT | YI);
    push("andi.T5", I_ANDI, 1'b0, 1'b0, RUN | CO | ZLOI | ctl(5'b00101));
    push("andi.T6", I_ANDI, 1'b0, 1'b0, RUN | ZLOO | GRA | RIN);

    fetch("st", I_ST, 1'b0);
    push("st.T4", I_ST, 1'b0, 1'b0, RUN | GRB | BAO | YI);
    push("st.T5", I_ST, 1'b0, 1'b0, RUN | CO | ZLOI | ctl(5'b00011));
    push("st.T6", I_ST, 1'b0, 1'b0, RUN | ZLOO | MARI);
    push("st.T7", I_ST, 1'b0, 1'b0, RUN | GRA | ROUT | MDRI);
    push("st.T8", I_ST, 1'b0, 1'b0, RUN | WR);

    fetch("neg", I_NEG, 1'b0);
    push("neg.T4", I_NEG, 1'b0, 1'b0, RUN | GRB | ROUT | ZLOI | ctl(5'b10001));
    push("neg.T5", I_NEG, 1'b0, 1'b0, RUN | ZLOO | GRA | RIN);

    fetch("mfhi", I_MFHI, 1'b0);
    push("mfhi.T4", I_MFHI, 1'b0, 1'b0, RUN | HIO | GRA | RIN);

    fetch("nop", I_NOP, 1'b0);
    push("nop.T4", I_NOP, 1'b0, 1'b0, RUN);

    // pause at T0, then resume
    push("stop.T0", I_NOP, 1'b0, 1'b1, RUN);
    push("stopped", I_NOP, 1'b0, 1'b1, 36'd0);
    push("stopped", I_NOP, 1'b0, 1'b1, 36'd0);
    push("stopped.rel", I_NOP, 1'b0, 1'b0, 36'd0);
    fetch("resume", I_NOP, 1'b0);
    push("resume.T4", I_NOP, 1'b0, 1'b0, RUN);

    // stop raised mid-mul: the mul runs to T7 before pausing
    fetch("mul", I_MUL, 1'b0);
    push("mul.T4", I_MUL, 1'b0, 1'b1, RUN | GRA | ROUT | YI);
    push("mul.T5", I_MUL, 1'b0, 1'b1, RUN | GRB | ROUT | ZHII | ZLOI | ctl(5'b01111));
    push("mul.T6", I_MUL, 1'b0, 1'b1, RUN | ZLOO | LOI);
    push("mul.T7", I_MUL, 1'b0, 1'b1, RUN | ZHIO | HII);
    push("mul.stopT0", I_HALT, 1'b0, 1'b1, RUN);
    push("mul.stopped", I_HALT, 1'b0, 1'b0, 36'd0);

    fetch("halt", I_HALT, 1'b0);
    push("halt.T4", I_HALT, 1'b0, 1'b0, RUN);
    for (int k = 0; k < 20; k++) push("halted", I_HALT, 1'b0, 1'b0, 36'd0);
    drain();

    #3 Clear = 1'b0;
    #1 chk("clear.async", obs, DPC);
    @(negedge Clock);
    chk("clear.hold", obs, DPC);
    Clear = 1'b1;
    push("post.T0", I_NOP, 1'b0, 1'b0, RUN | PCO | MARI | INCPC);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
Hardwired control sequencer for the single-bus Mini SRC datapath, sitting directly upstream of it. It drives every datapath strobe (register in/out enables, register-select gates, ALU CONTROL, memory Read/Write, IncPC, Con_In) from a step-counter state machine. The FSM is sequenced by the instruction register contents and ConFF_Out fed back from the datapath. It implements fetch plus execute sequences for the Mini SRC instruction classes listed below.

Parameters:
ALU_ADD, 5'b00011, ALU CONTROL code for add; used for address/branch-target computation and addi
ALU_AND, 5'b00101, CONTROL code used for andi
ALU_OR, 5'b00110, CONTROL code used for ori

Ports:
Clock  in  1  system clock, rising edge
Clear  in  1  reset, asynchronous, active-low
IR  in  32  instruction register value; opcode = IR[31:27]
ConFF_Out  in  1  branch condition from datapath
Stop  in  1  pause request
Run  out  1  high while executing instructions
DP_Clear  out  1  active-high datapath clear
CONTROL  out  5  ALU operation select
IncPC, Read, Write, Con_In  out  1 each  datapath strobes
PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out  out  1 each  bus drivers
PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In, InPort_In, OutPort_In  out  1 each  register loads
G_RA, G_RB, G_RC, R_In, R_Out, BA_Out  out  1 each  select/encode controls

Behaviour:
- Clear low: async entry to RESET. In RESET, DP_Clear=1, all other outputs 0, Run=0, CONTROL=0. The first rising edge with Clear high moves the FSM to T0.
- All outputs are decoded combinationally from the registered state and IR. One state per clock.
- Run=1 in every state except RESET, STOPPED and HALT.
- Stop is sampled only in T0. If Stop=1, go to STOPPED with all strobes 0. Leave STOPPED to T0 when Stop=0. A fetch already in progress always completes its instruction.
- Fetch:
  - T0: PC_Out, MAR_In, IncPC.
  - T1: Read (RAM latency cycle).
  - T2: Read, MDR_In.
  - T3: MDR_Out, IR_In.
  - T4 onward is execute.
- Every execute sequence returns to T0 after its last step.
- add, sub, and, or, shr, shra, shl, ror, rol (opcodes 00011–01011):
  - T4: G_RB, R_Out, Y_In.
  - T5: G_RC, R_Out, CONTROL=IR[31:27], ZLO_In.
  - T6: ZLO_Out, G_RA, R_In.
- addi, andi, ori (01100–01110), same shape as above:
  - T5 uses C_Out with CONTROL = ALU_ADD, ALU_AND or ALU_OR respectively.
- mul, div (01111, 10000):
  - T4: G_RA, R_Out, Y_In.
  - T5: G_RB, R_Out, CONTROL=opcode, ZHI_In, ZLO_In.
  - T6: ZLO_Out, LO_In.
  - T7: ZHI_Out, HI_In.
- neg, not (10001, 10010):
  - T4: G_RB, R_Out, CONTROL=opcode, ZLO_In.
  - T5: ZLO_Out, G_RA, R_In.
- ld (00000):
  - T4: G_RB, BA_Out, Y_In.
  - T5: C_Out, CONTROL=ALU_ADD, ZLO_In.
  - T6: ZLO_Out, MAR_In.
  - T7: Read.
  - T8: Read, MDR_In.
  - T9: MDR_Out, G_RA, R_In.
- ldi (00001): T4–T5 as ld, then T6: ZLO_Out, G_RA, R_In.
- st (00010): T4–T6 as ld, then:
  - T7: G_RA, R_Out, MDR_In, with Read=0.
  - T8: Write.
- br (10011):
  - T4: G_RA, R_Out, Con_In.
  - T5: PC_Out, Y_In.
  - T6: C_Out, CONTROL=ALU_ADD, ZLO_In.
  - T7: ZLO_Out, and PC_In only if ConFF_Out=1.
- jr (10100): T4: G_RA, R_Out, PC_In.
- in (10110):
  - T4: InPort_In.
  - T5: InPort_Out, G_RA, R_In.
- out (10111): T4: G_RA, R_Out, OutPort_In.
- mfhi (11000): T4: HI_Out, G_RA, R_In.
- mflo (11001): T4: LO_Out, G_RA, R_In.
- nop (11010), jal and all undefined opcodes: T4 with no strobes, then T0.
- halt (11011): HALT state, all strobes 0, Run=0. Only Clear exits HALT.
- Each step asserts at most one bus driver.
- Clear mid-sequence aborts immediately. Partial register or memory updates are not rolled back.

Test Plan:
- Clear low for 2 cycles, then high -> DP_Clear=1 and all strobes 0 during reset; T0 on the next edge shows PC_Out=MAR_In=IncPC=1, Run=1.
- IR=add R1,R2,R3 (0x18918000) -> exact T4/T5/T6 strobes; CONTROL=00011 at T5; next T0 after 7 cycles total.
- IR=ld R2,0x55(R0) (0x01000055) -> BA_Out at T4, MAR_In at T6, MDR_In at T8, R_In with G_RA at T9; 10 cycles total.
- IR=br with ConFF_Out=0, then a second br with ConFF_Out=1 -> PC_In stays 0 for the first and is 1 at T7 for the second; Con_In=1 at T4 in both.
- IR=halt (0xD8000000) -> Run falls after T4 and stays low for 20 cycles; Clear low returns the FSM to RESET.
- Stop=1 at T0 -> STOPPED with zero strobes; Stop=0 -> fetch resumes at T0 the next cycle. Stop raised mid-mul -> the mul completes through T7 before pausing.
